// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and defaults for the instruction fetch sequencer.
//   - fetch_state_t    : sequencer state (opcode byte, extension byte, hold)
//   - LONG_OP_MASK_DEF : default bitmap of 2-byte opcodes (C..F are long)
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      S_OP   = 2'd0,
      S_EXT  = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   localparam logic [15:0] LONG_OP_MASK_DEF = 16'hF000;

endpackage : fetch_pkg

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch sequencer between the PC register and the decoder.
//   Reads ROM bytes at the current PC, assembles 1- or 2-byte instructions,
//   steers the PC (sequential advance or taken branch) and presents each
//   complete instruction on a valid/ready handshake.
//
// Ports
//   clk          in   rising-edge clock
//   Rst          in   asynchronous active-low reset
//   pc_addr      in   current PC value
//   pc_newaddr   out  next PC value (to PC register load input)
//   pc_en        out  PC load strobe
//   rom_data     in   ROM byte at pc_addr (combinational read)
//   instr_valid  out  opcode/operand/target hold a complete instruction
//   instr_ready  in   decoder accepts the instruction this cycle
//   opcode       out  byte0 upper nibble
//   operand      out  byte0 lower nibble
//   target       out  {operand, byte1} for long opcodes, else 0
//   branch_req   in   taken branch, honoured only on an accepting cycle
//   branch_addr  in   branch destination
//   instr_count  out  accepted-instruction counter (FETCH_PERF_EN only)
//
// Configuration
//   FETCH_PERF_EN : when defined, adds the saturating 16-bit instr_count
//                   port and counter.
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                          ADDR_W       = 12,
   parameter int                          OP_W         = 4,
   parameter logic [(1 << OP_W)-1:0]      LONG_OP_MASK = LONG_OP_MASK_DEF
) (
   input  logic                 clk,
   input  logic                 Rst,
   input  logic [ADDR_W-1:0]    pc_addr,
   output logic [ADDR_W-1:0]    pc_newaddr,
   output logic                 pc_en,
   input  logic [2*OP_W-1:0]    rom_data,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [OP_W-1:0]      opcode,
   output logic [OP_W-1:0]      operand,
   output logic [ADDR_W-1:0]    target,
   input  logic                 branch_req,
   input  logic [ADDR_W-1:0]    branch_addr
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]          instr_count
`endif
);

   fetch_state_t            r_state;
   fetch_state_t            w_next;
   logic [OP_W-1:0]         r_opcode;
   logic [OP_W-1:0]         r_operand;
   logic [ADDR_W-1:0]       r_target;
   logic                    w_accept;
   logic [OP_W-1:0]         w_rom_op;
   logic [ADDR_W-1:0]       w_pc_inc;
   logic [ADDR_W-1:0]       w_ext_target;

   assign w_rom_op     = rom_data[2*OP_W-1:OP_W];
   // Natural ADDR_W wrap gives the modulo-2^ADDR_W PC advance.
   assign w_pc_inc     = pc_addr + ADDR_W'(1);
   assign w_ext_target = ADDR_W'({r_operand, rom_data});

   assign opcode  = r_opcode;
   assign operand = r_operand;
   assign target  = r_target;

   // ---------------- state register and instruction latches ----------------
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_state   <= S_OP;
         r_opcode  <= '0;
         r_operand <= '0;
         r_target  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_OP: begin
               r_opcode  <= w_rom_op;
               r_operand <= rom_data[OP_W-1:0];
               r_target  <= '0;
            end
            S_EXT: begin
               r_target <= w_ext_target;
            end
            default: ;
         endcase
      end
   end

   // ---------------- next state and PC steering ----------------
   always_comb begin
      w_next      = r_state;
      pc_en       = 1'b0;
      pc_newaddr  = '0;
      instr_valid = 1'b0;
      w_accept    = 1'b0;

      case (r_state)
         S_OP: begin
            pc_en      = 1'b1;
            pc_newaddr = w_pc_inc;
            w_next     = LONG_OP_MASK[w_rom_op] ? S_EXT : S_HOLD;
         end
         S_EXT: begin
            pc_en      = 1'b1;
            pc_newaddr = w_pc_inc;
            w_next     = S_HOLD;
         end
         S_HOLD: begin
            instr_valid = 1'b1;
            w_accept    = instr_ready;
            w_next      = w_accept ? S_OP : S_HOLD;
            // PC already points at the next byte; it only moves on a branch.
            if (w_accept && branch_req) begin
               pc_en      = 1'b1;
               pc_newaddr = branch_addr;
            end
         end
         default: w_next = S_OP;
      endcase

      // The PC strobe must stay quiet while reset is held, even though the
      // reset state (S_OP) would otherwise request an advance.
      if (!Rst) begin
         pc_en      = 1'b0;
         pc_newaddr = '0;
      end
   end

`ifdef FETCH_PERF_EN
   // ---------------- accepted-instruction counter ----------------
   logic [15:0] r_count;

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_count <= '0;
      end else if (w_accept && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign instr_count = r_count;
`else
   // No performance counter in this build.
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit: provides the PC register and a 4K ROM around the
//   DUT, runs directed scenarios with literal expectations, then randomized
//   handshake/branch traffic checked every cycle against a transaction-level
//   model of the instruction stream.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int ADDR_W = 12;
   localparam int OP_W   = 4;

   logic              clk = 1'b0;
   logic              Rst = 1'b0;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_newaddr;
   logic              pc_en;
   logic [7:0]        rom_data;
   logic              instr_valid;
   logic              instr_ready = 1'b0;
   logic [OP_W-1:0]   opcode;
   logic [OP_W-1:0]   operand;
   logic [ADDR_W-1:0] target;
   logic              branch_req = 1'b0;
   logic [ADDR_W-1:0] branch_addr = '0;
`ifdef FETCH_PERF_EN
   logic [15:0]       instr_count;
`endif

   logic [7:0] rom [0:4095];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(ADDR_W), .OP_W(OP_W), .LONG_OP_MASK(16'hF000)) dut (
      .clk         (clk),
      .Rst         (Rst),
      .pc_addr     (pc_q),
      .pc_newaddr  (pc_newaddr),
      .pc_en       (pc_en),
      .rom_data    (rom_data),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .operand     (operand),
      .target      (target),
      .branch_req  (branch_req),
      .branch_addr (branch_addr)
`ifdef FETCH_PERF_EN
      ,
      .instr_count (instr_count)
`endif
   );

   // System-side PC register and ROM
   always @(posedge clk or negedge Rst) begin
      if (!Rst)       pc_q <= '0;
      else if (pc_en) pc_q <= pc_newaddr;
   end

   assign rom_data = rom[pc_q];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // The instruction starting at address m_start occupies m_len bytes and is
   // visible after m_len fetch cycles; after acceptance the next one starts
   // at m_start+m_len or at the branch address.
   logic [ADDR_W-1:0] m_start;
   logic [3:0]        m_op;
   logic [3:0]        m_opd;
   logic [ADDR_W-1:0] m_tgt;
   int                m_len;
   int                m_wait;
   int                m_count;

   task automatic model_load();
      logic [7:0] b0;
      logic [7:0] b1;
      b0    = rom[m_start];
      b1    = rom[12'(m_start + 12'd1)];
      m_op  = b0[7:4];
      m_opd = b0[3:0];
      if (b0[7:4] >= 4'hC) begin
         m_len = 2;
         m_tgt = {b0[3:0], b1};
      end else begin
         m_len = 1;
         m_tgt = '0;
      end
      m_wait = m_len;
   endtask

   initial begin
      logic [ADDR_W-1:0] exp_addr;
      logic [ADDR_W-1:0] end_addr;
      m_start = '0;
      m_count = 0;
      forever begin
         @(negedge clk);
         if (!Rst) begin
            chk("rst_valid",   {31'b0, instr_valid}, 32'd0);
            chk("rst_pc_en",   {31'b0, pc_en},       32'd0);
            chk("rst_newaddr", {20'b0, pc_newaddr},  32'd0);
            chk("rst_opcode",  {28'b0, opcode},      32'd0);
            chk("rst_target",  {20'b0, target},      32'd0);
            m_start = '0;
            m_count = 0;
            model_load();
         end else if (m_wait > 0) begin
            exp_addr = m_start + 12'(m_len - m_wait);
            chk("fetch_valid",   {31'b0, instr_valid}, 32'd0);
            chk("fetch_pc_en",   {31'b0, pc_en},       32'd1);
            chk("fetch_pc",      {20'b0, pc_q},        {20'b0, exp_addr});
            chk("fetch_newaddr", {20'b0, pc_newaddr},  {20'b0, 12'(exp_addr + 12'd1)});
            m_wait--;
         end else begin
            end_addr = m_start + 12'(m_len);
            chk("hold_valid",   {31'b0, instr_valid}, 32'd1);
            chk("hold_opcode",  {28'b0, opcode},      {28'b0, m_op});
            chk("hold_operand", {28'b0, operand},     {28'b0, m_opd});
            chk("hold_target",  {20'b0, target},      {20'b0, m_tgt});
            chk("hold_pc",      {20'b0, pc_q},        {20'b0, end_addr});
            if (instr_ready && branch_req) begin
               chk("branch_pc_en",   {31'b0, pc_en},      32'd1);
               chk("branch_newaddr", {20'b0, pc_newaddr}, {20'b0, branch_addr});
               m_start = branch_addr;
            end else begin
               chk("hold_pc_en", {31'b0, pc_en}, 32'd0);
               if (instr_ready) m_start = end_addr;
            end
            if (instr_ready) begin
               if (m_count != 65535) m_count++;
               model_load();
            end
         end
`ifdef FETCH_PERF_EN
         chk("instr_count", {16'b0, instr_count}, m_count);
`endif
      end
   end

   // ---------------- directed scenarios then random traffic ----------------
   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
      rom[12'h000] = 8'h35;
      rom[12'h001] = 8'hC2;
      rom[12'h002] = 8'h7A;
      rom[12'h359] = 8'h41;
      rom[12'hFFF] = 8'hD3;

      Rst = 1'b0; instr_ready = 1'b1; branch_req = 1'b0; branch_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("t1_reset_valid", {31'b0, instr_valid}, 32'd0);
      chk("t1_reset_pc_en", {31'b0, pc_en},       32'd0);
      Rst = 1'b1;

      // Short instruction 8'h35 at address 0
      @(negedge clk);
      chk("t1_op_pc_en",   {31'b0, pc_en},      32'd1);
      chk("t1_op_newaddr", {20'b0, pc_newaddr}, 32'h001);
      @(negedge clk);
      chk("t1_valid",   {31'b0, instr_valid}, 32'd1);
      chk("t1_opcode",  {28'b0, opcode},      32'h3);
      chk("t1_operand", {28'b0, operand},     32'h5);
      chk("t1_target",  {20'b0, target},      32'h000);

      // Long instruction C2 7A; decoder stalls once it is presented
      @(posedge clk); #1;
      @(posedge clk); #1;
      instr_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_valid",  {31'b0, instr_valid}, 32'd1);
      chk("t2_opcode", {28'b0, opcode},      32'hC);
      chk("t2_target", {20'b0, target},      32'h27A);
      chk("t2_pc",     {20'b0, pc_q},        32'h003);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("t3_stall_target", {20'b0, target}, 32'h27A);
         chk("t3_stall_pc_en",  {31'b0, pc_en},  32'd0);
         chk("t3_stall_pc",     {20'b0, pc_q},   32'h003);
      end

      // Release with a taken branch to 12'h359
      @(posedge clk); #1;
      instr_ready = 1'b1; branch_req = 1'b1; branch_addr = 12'h359;
      @(negedge clk);
      chk("t4_pc_en",   {31'b0, pc_en},      32'd1);
      chk("t4_newaddr", {20'b0, pc_newaddr}, 32'h359);
      @(posedge clk); #1;
      branch_req = 1'b0;
      @(negedge clk);
      chk("t4_one_accept", {31'b0, instr_valid}, 32'd0);
      chk("t4_pc",         {20'b0, pc_q},        32'h359);

      // Branch to the last address, where a long opcode wraps
      @(posedge clk); #1;
      branch_req = 1'b1; branch_addr = 12'hFFF;
      @(negedge clk);
      chk("t4_opcode",  {28'b0, opcode},      32'h4);
      chk("t4_operand", {28'b0, operand},     32'h1);
      @(posedge clk); #1;
      branch_req = 1'b0;
      @(negedge clk);
      chk("t5_pc",      {20'b0, pc_q},       32'hFFF);
      chk("t5_newaddr", {20'b0, pc_newaddr}, 32'h000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_ext_pc", {20'b0, pc_q}, 32'h000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_opcode", {28'b0, opcode}, 32'hD);
      chk("t5_target", {20'b0, target}, 32'h335);
      chk("t5_pc",     {20'b0, pc_q},   32'h001);

      // Reset while the long C2 instruction is in its extension byte
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t6_pre_opcode", {28'b0, opcode}, 32'hC);
      Rst = 1'b0;
      #1;
      chk("t6_valid",  {31'b0, instr_valid}, 32'd0);
      chk("t6_opcode", {28'b0, opcode},      32'h0);
      chk("t6_pc",     {20'b0, pc_q},        32'h000);
      @(posedge clk); #1;
      Rst = 1'b1;

      // Randomized handshake and branch traffic
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         instr_ready = ($urandom_range(0, 9) < 7);
         branch_req  = ($urandom_range(0, 3) == 0);
         branch_addr = 12'($urandom);
         if (c == 1500) Rst = 1'b0;
         if (c == 1502) Rst = 1'b1;
      end

      @(posedge clk); #1;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fetch_unit
